// File: rtl/mips_data_bus.sv
// ---------------------------------------------------------------------------
// mips_data_bus
//
// Data-side bus controller for the MIPS core. It decodes the ALU byte
// address of each load/store into one of four regions:
//   RAM    : 0x1001_0000 .. 0x1001_0000 + 4*MEMORY_DEPTH - 1
//   OUT k  : 0xFFFF_0000 + 4k   (read/write, 32-bit registered ports)
//   IN k   : 0xFFFF_0100 + 4k   (read-only, synchronized, zero-extended)
//   STATUS : 0xFFFF_0200        (read-only, per-input change flags)
//
// RAM loads take one wait state: the synchronous RAM returns data one
// cycle after the address, so the first cycle of a RAM load stalls the
// processor and the second cycle delivers RamReadData.
//
// Handshake: the processor presents MemRead or MemWrite together with
// Address/WriteData and keeps them stable while Stall is high. An access
// completes in any cycle where Stall is low. Exactly one of MemRead and
// MemWrite may be high; both high is treated as an illegal access.
//
// Illegal accesses (unmapped, misaligned, store to IN/STATUS, read+write)
// are dropped, return 0, and set the sticky BusError flag.
//
// Optional feature macro: MIPS_BUS_EDGE_CAPTURE_EN
//   defined   : change flags and the STATUS register are built.
//   undefined : no flag logic; STATUS reads return 0 without error.
//
// DebugState exposes the load FSM state (0 = IDLE, 1 = WAIT).
// ---------------------------------------------------------------------------
module mips_data_bus #(
   parameter int MEMORY_DEPTH = 1024,
   parameter int NUM_OUT      = 2,
   parameter int NUM_IN       = 2,
   parameter int IN_WIDTH     = 8
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic                            MemRead,
   input  logic                            MemWrite,
   input  logic [31:0]                     Address,
   input  logic [31:0]                     WriteData,
   output logic [31:0]                     ReadData,
   output logic                            Stall,
   output logic                            BusError,
   output logic [$clog2(MEMORY_DEPTH)-1:0] RamAddress,
   output logic [31:0]                     RamWriteData,
   output logic                            RamWe,
   input  logic [31:0]                     RamReadData,
   input  logic [NUM_IN*IN_WIDTH-1:0]      PortIn,
   output logic [NUM_OUT*32-1:0]           PortOut,
   output logic                            DebugState
);

   // ------------------------------------------------------------------------
   // Address map constants
   // ------------------------------------------------------------------------
   localparam int          AW          = $clog2(MEMORY_DEPTH);
   localparam logic [31:0] RAM_BASE    = 32'h1001_0000;
   localparam logic [31:0] OUT_BASE    = 32'hFFFF_0000;
   localparam logic [31:0] IN_BASE     = 32'hFFFF_0100;
   localparam logic [31:0] STATUS_ADDR = 32'hFFFF_0200;
   localparam logic [31:0] RAM_BYTES   = 32'(4 * MEMORY_DEPTH);
   localparam logic [31:0] OUT_BYTES   = 32'(4 * NUM_OUT);
   localparam logic [31:0] IN_BYTES    = 32'(4 * NUM_IN);

   // ------------------------------------------------------------------------
   // Load FSM state
   // ------------------------------------------------------------------------
   typedef enum logic {
      IDLE = 1'b0,
      WAIT = 1'b1
   } busState_t;

   busState_t state;
   busState_t nextState;

   // ------------------------------------------------------------------------
   // Decode signals
   // ------------------------------------------------------------------------
   logic [31:0] ramOffset;
   logic [31:0] outOffset;
   logic [31:0] inOffset;
   logic [2:0]  outIdx;
   logic [2:0]  inIdx;
   logic        hitRam;
   logic        hitOut;
   logic        hitIn;
   logic        hitStatus;
   logic        mapped;
   logic        aligned;
   logic        anyAccess;
   logic        conflict;
   logic        badAccess;
   logic        goodRead;
   logic        goodWrite;

   // Output port registers and input synchronizers
   logic [31:0]                outReg [NUM_OUT];
   logic [NUM_IN*IN_WIDTH-1:0] syncMeta;
   logic [NUM_IN*IN_WIDTH-1:0] syncIn;

`ifdef MIPS_BUS_EDGE_CAPTURE_EN
   logic [NUM_IN*IN_WIDTH-1:0] syncPrev;
   logic [NUM_IN-1:0]          changeNow;
   logic [NUM_IN-1:0]          changeFlag;
   logic                       statusRead;
`endif

   // Offsets relative to each region base. An address below a base wraps
   // to a huge offset, so a single unsigned "offset < size" compare is a
   // complete range check; offsets past the end are unmapped, not wrapped.
   always_comb begin
      ramOffset = Address - RAM_BASE;
      outOffset = Address - OUT_BASE;
      inOffset  = Address - IN_BASE;
      outIdx    = outOffset[4:2];
      inIdx     = inOffset[4:2];
      hitRam    = (ramOffset < RAM_BYTES);
      hitOut    = (outOffset < OUT_BYTES);
      hitIn     = (inOffset < IN_BYTES);
      hitStatus = (Address == STATUS_ADDR);
      mapped    = hitRam | hitOut | hitIn | hitStatus;
      aligned   = (Address[1:0] == 2'b00);
   end

   // Access classification. Nothing counts as an access while reset is
   // asserted, so Stall, RamWe and ReadData are quiet during reset.
   always_comb begin
      anyAccess = reset & (MemRead | MemWrite);
      conflict  = MemRead & MemWrite;
      badAccess = anyAccess &
                  (conflict | ~aligned | ~mapped |
                   (MemWrite & (hitIn | hitStatus)));
      goodRead  = anyAccess & ~badAccess & MemRead;
      goodWrite = anyAccess & ~badAccess & MemWrite;
   end

   // ------------------------------------------------------------------------
   // RAM side
   // ------------------------------------------------------------------------

   // RAM address, data and write strobe are pure functions of the request.
   always_comb begin
      RamAddress   = ramOffset[AW+1:2];
      RamWriteData = WriteData;
      RamWe        = goodWrite & hitRam;
   end

   // Load FSM state register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= nextState;
      end
   end

   // Load FSM next state and stall: a RAM load stalls once in IDLE, then
   // completes in WAIT; WAIT always returns to IDLE so back-to-back loads
   // each get their own wait state.
   always_comb begin
      nextState = state;
      Stall     = 1'b0;
      case (state)
         IDLE: begin
            if (goodRead && hitRam) begin
               Stall     = 1'b1;
               nextState = WAIT;
            end
         end
         WAIT: begin
            nextState = IDLE;
         end
         default: begin
            nextState = IDLE;
         end
      endcase
   end

   assign DebugState = (state == WAIT);

   // ------------------------------------------------------------------------
   // Output ports
   // ------------------------------------------------------------------------

   // Output port registers load on a legal store to their address.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int k = 0; k < NUM_OUT; k++) begin
            outReg[k] <= '0;
         end
      end else if (goodWrite && hitOut) begin
         for (int k = 0; k < NUM_OUT; k++) begin
            if (outIdx == 3'(k)) begin
               outReg[k] <= WriteData;
            end
         end
      end
   end

   // Flatten the port registers onto the PortOut bus.
   always_comb begin
      PortOut = '0;
      for (int k = 0; k < NUM_OUT; k++) begin
         PortOut[k*32 +: 32] = outReg[k];
      end
   end

   // ------------------------------------------------------------------------
   // Input ports
   // ------------------------------------------------------------------------

   // Two-flop synchronizer on every input bit; PortIn is asynchronous.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         syncMeta <= '0;
         syncIn   <= '0;
      end else begin
         syncMeta <= PortIn;
         syncIn   <= syncMeta;
      end
   end

`ifdef MIPS_BUS_EDGE_CAPTURE_EN
   // Per-port change detect on the synchronized value.
   always_comb begin
      changeNow  = '0;
      statusRead = goodRead & hitStatus;
      for (int k = 0; k < NUM_IN; k++) begin
         changeNow[k] = |(syncIn[k*IN_WIDTH +: IN_WIDTH] ^
                          syncPrev[k*IN_WIDTH +: IN_WIDTH]);
      end
   end

   // Change flags: a STATUS read clears every flag it returned as 1, but a
   // change seen in the same cycle keeps (or sets) its flag.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         syncPrev   <= '0;
         changeFlag <= '0;
      end else begin
         syncPrev <= syncIn;
         if (statusRead) begin
            changeFlag <= changeNow;
         end else begin
            changeFlag <= changeFlag | changeNow;
         end
      end
   end
`endif

   // ------------------------------------------------------------------------
   // Read data mux
   // ------------------------------------------------------------------------

   // Load data: I/O reads are served from registers in the same cycle; RAM
   // data is only valid in the WAIT cycle. Anything else returns 0.
   always_comb begin
      ReadData = '0;
      if (goodRead) begin
         if (hitRam) begin
            if (state == WAIT) begin
               ReadData = RamReadData;
            end
         end else if (hitOut) begin
            for (int k = 0; k < NUM_OUT; k++) begin
               if (outIdx == 3'(k)) begin
                  ReadData = outReg[k];
               end
            end
         end else if (hitIn) begin
            for (int k = 0; k < NUM_IN; k++) begin
               if (inIdx == 3'(k)) begin
                  ReadData = 32'(syncIn[k*IN_WIDTH +: IN_WIDTH]);
               end
            end
         end else if (hitStatus) begin
`ifdef MIPS_BUS_EDGE_CAPTURE_EN
            ReadData = 32'(changeFlag);
`else
            ReadData = '0;
`endif
         end
      end
   end

   // ------------------------------------------------------------------------
   // Error flag
   // ------------------------------------------------------------------------

   // Sticky bus error: set by any illegal access, cleared only by reset.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         BusError <= 1'b0;
      end else if (badAccess) begin
         BusError <= 1'b1;
      end
   end

endmodule
